johnson_slot_arbiter: RTL and testbench
=======================================

Name: johnson_slot_arbiter

Overview:
- Eight-requester time-slot arbiter sequenced by an internal 4-bit Johnson counter.
- Each Johnson phase owns one slot; the arbiter grants that slot's requester, bounds its hold time, then advances.
- Supports fixed TDM stepping and idle-skip round-robin jumps.
- Sits between shared-resource requesters and the resource; the Johnson state is exported for decode and debug.

Parameters:
- MAX_HOLD, 4: maximum consecutive grant cycles per slot visit (>=1). Hold counter width = clog2(MAX_HOLD)+1.

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  asynchronous, active-high reset
- en  input  1  run enable; 0 freezes all state and forces grant to 0
- skip_idle  input  1  0 = fixed TDM single-step; 1 = jump to the next requesting slot
- req  input  8  request per slot, level-sensitive
- grant  output  8  one-hot grant, combinational from state and inputs
- slot  output  3  current slot index, binary
- jstate  output  4  Johnson state {A,B,C,E}
- frame_wrap  output  1  registered 1-cycle pulse after an advance that wraps
- err_illegal  output  1  registered 1-cycle pulse on illegal Johnson state recovery

Behaviour:
- Johnson step: A<=!E, B<=A, C<=B, E<=C.
- Slot encoding {A,B,C,E}: 0=0000, 1=1000, 2=1100, 3=1110, 4=1111, 5=0111, 6=0011, 7=0001.
- slot is decoded from jstate. All 8 other codes are illegal.
- Reset (clear=1, asynchronous): jstate=0000, slot=0, hold_cnt=0, frame_wrap=0, err_illegal=0. grant=0 while clear=1, regardless of req.
- grant[i] = en & legal & (slot==i) & req[i]. Zero latency from req.
- Active = grant != 0.
- Advance condition (en=1, legal): !active OR hold_cnt==MAX_HOLD-1.
  - On advance: hold_cnt<=0.
  - Otherwise, if active: hold_cnt<=hold_cnt+1.
- Next slot, skip_idle=0: one Johnson step (slot+1 mod 8). Empty slots cost exactly 1 cycle.
- Next slot, skip_idle=1: first i in slot+1..slot+7 (mod 8) with req[i]=1.
  - If none, and req[slot]=1: stay on the current slot; this counts as an advance, so hold_cnt<=0 and a new visit starts.
  - If no req at all: single step.
  - The jump loads the target Johnson code directly and completes in one cycle.
- frame_wrap<=1 for one cycle after an advance where new slot <= old slot. This includes the 7->0 step and the self-reselect case.
- Illegal jstate (reachable by fault or force only):
  - grant=0 that cycle.
  - Next edge: jstate<=0000, hold_cnt<=0, err_illegal<=1 for one cycle.
  - Recovery happens even when en=0.
- en=0 (legal state): jstate, hold_cnt, and slot are held; grant=0; frame_wrap=0 and err_illegal=0 next cycle.
- Simultaneous events:
  - clear dominates everything.
  - A req drop on the hold-expiry cycle still results in a single advance.
  - A req change mid-visit takes effect combinationally on grant. The current slot loses its grant immediately when its req drops; the advance happens on the next edge.
- Mid-operation clear: immediate return to slot 0. No pulse is generated on release.

Test Plan:
- Reset, en=1, skip_idle=0, req=0 -> jstate walks 0000,1000,1100,1110,1111,0111,0011,0001,0000, one per cycle; frame_wrap pulses once per 8 cycles; grant stays 0.
- MAX_HOLD=4, req=8'hFF continuously, skip_idle=0 -> each grant bit high for 4 cycles in order 0..7; full frame = 32 cycles; no two grant bits high at once.
- skip_idle=1, req=8'b0010_0100, start slot 0 -> slot jumps 0->2 in 1 cycle; grant[2] for 4 cycles; then slot->5, grant[5] for 4 cycles; then slot->2 with a frame_wrap pulse.
- skip_idle=1, only req[3]=1 held, slot=3 -> grant[3] continuous; hold_cnt restarts every 4 cycles; frame_wrap pulses every 4 cycles.
- Force jstate=0100 for one cycle with req=8'hFF -> grant=0 that cycle; next cycle jstate=0000, err_illegal=1 for exactly one cycle; also check with en=0.
- Assert clear mid-visit at slot 5 (between clock edges) -> grant=0 and jstate=0000 immediately; release with en=0 -> state holds at 0000; set en=1 -> normal stepping from slot 0.

Source files
------------

// File: rtl/johnson_slot_arbiter.sv
// Purpose: eight-slot time-division arbiter sequenced by a 4-bit Johnson counter, with bounded hold per visit.
// Latency: grant is combinational from state and req (zero cycles); frame_wrap/err_illegal are registered pulses.
// Backpressure: none; en=0 freezes the sequencer and forces grant low, requesters simply keep req asserted.
module johnson_slot_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       en,
    input  logic       skip_idle,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] slot,
    output logic [3:0] jstate,
    output logic       frame_wrap,
    output logic       err_illegal
);

    localparam int              HW        = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

    // Johnson code {A,B,C,E} for each binary slot index.
    function automatic logic [3:0] slot_to_code(input logic [2:0] s);
        logic [3:0] c;
        case (s)
            3'd0:    c = 4'b0000;
            3'd1:    c = 4'b1000;
            3'd2:    c = 4'b1100;
            3'd3:    c = 4'b1110;
            3'd4:    c = 4'b1111;
            3'd5:    c = 4'b0111;
            3'd6:    c = 4'b0011;
            default: c = 4'b0001;
        endcase
        return c;
    endfunction

    logic [3:0]    jstate_q;
    logic [HW-1:0] hold_q;
    logic          wrap_q;
    logic          err_q;

    logic [3:0]    jstate_d;
    logic [HW-1:0] hold_d;
    logic          wrap_d;
    logic          err_d;

    logic          legal;
    logic [2:0]    cur_slot;
    logic [2:0]    nxt_slot;
    logic          active;
    logic          advance;

    // Decode the Johnson register into a slot index and flag the eight unreachable codes.
    always_comb begin
        legal    = 1'b1;
        cur_slot = 3'd0;
        case (jstate_q)
            4'b0000: cur_slot = 3'd0;
            4'b1000: cur_slot = 3'd1;
            4'b1100: cur_slot = 3'd2;
            4'b1110: cur_slot = 3'd3;
            4'b1111: cur_slot = 3'd4;
            4'b0111: cur_slot = 3'd5;
            4'b0011: cur_slot = 3'd6;
            4'b0001: cur_slot = 3'd7;
            default: legal    = 1'b0;
        endcase
    end

    // Grant the current slot's requester only; held low during clear, when disabled, or in an illegal state.
    always_comb begin
        grant = 8'd0;
        if (!clear && en && legal) begin
            grant[cur_slot] = req[cur_slot];
        end
    end

    assign active  = |grant;
    assign advance = !active || (hold_q == HOLD_LAST);

    // Pick the next slot: a plain step, or in skip mode the nearest requesting slot after the current one.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        found    = 1'b0;
        idx      = 3'd0;
        nxt_slot = cur_slot + 3'd1;
        if (skip_idle) begin
            for (int i = 1; i < 8; i++) begin
                idx = cur_slot + 3'(i);
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    nxt_slot = idx;
                end
            end
            // Only the current slot is asking: re-select it as a fresh visit.
            if (!found && req[cur_slot]) begin
                nxt_slot = cur_slot;
            end
        end
    end

    // Next-state logic: illegal recovery first (independent of en), then freeze, advance, or extend the visit.
    always_comb begin
        jstate_d = jstate_q;
        hold_d   = hold_q;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        if (!legal) begin
            jstate_d = 4'b0000;
            hold_d   = '0;
            err_d    = 1'b1;
        end else if (en) begin
            if (advance) begin
                jstate_d = slot_to_code(nxt_slot);
                hold_d   = '0;
                wrap_d   = (nxt_slot <= cur_slot);
            end else begin
                hold_d   = hold_q + HW'(1);
            end
        end
    end

    // State register with asynchronous clear back to slot 0.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            jstate_q <= 4'b0000;
            hold_q   <= '0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            jstate_q <= jstate_d;
            hold_q   <= hold_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    // Export state, decoded slot and the registered pulses.
    always_comb begin
        jstate      = jstate_q;
        slot        = cur_slot;
        frame_wrap  = wrap_q;
        err_illegal = err_q;
    end

endmodule

// File: tb/tb_johnson_slot_arbiter.sv
module tb_johnson_slot_arbiter;

    logic       clk;
    logic       clear;
    logic       en;
    logic       skip_idle;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] slot;
    logic [3:0] jstate;
    logic       frame_wrap;
    logic       err_illegal;

    johnson_slot_arbiter #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .clear       (clear),
        .en          (en),
        .skip_idle   (skip_idle),
        .req         (req),
        .grant       (grant),
        .slot        (slot),
        .jstate      (jstate),
        .frame_wrap  (frame_wrap),
        .err_illegal (err_illegal)
    );

    typedef struct {
        string      nm;
        logic [7:0] g;
        logic [3:0] js;
        logic       fw;
        logic       er;
    } exp_t;

    exp_t       expq[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] jtab[8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input string fld, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h at %0t", nm, fld, act, req_v, $time);
        end
    endtask

    // Monitor: on each falling edge compare DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk(e.nm, "grant",       int'(grant),       int'(e.g));
                chk(e.nm, "jstate",      int'(jstate),      int'(e.js));
                chk(e.nm, "frame_wrap",  int'(frame_wrap),  int'(e.fw));
                chk(e.nm, "err_illegal", int'(err_illegal), int'(e.er));
                for (int k = 0; k < 8; k++) begin
                    if (jtab[k] == e.js) chk(e.nm, "slot", int'(slot), k);
                end
            end
        end
    end

    task automatic push_exp(input string nm, input logic [7:0] g, input logic [3:0] js,
                            input logic fw, input logic er);
        exp_t e;
        e.nm = nm; e.g = g; e.js = js; e.fw = fw; e.er = er;
        expq.push_back(e);
    endtask

    // Drive one cycle of inputs (called just after a rising edge) and queue that cycle's expectation.
    task automatic step(input string nm, input logic e, input logic sk, input logic [7:0] r,
                        input logic [7:0] g, input logic [3:0] js, input logic fw, input logic er);
        en        = e;
        skip_idle = sk;
        req       = r;
        push_exp(nm, g, js, fw, er);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        logic [7:0] g;
        int         s;
        jtab[0] = 4'b0000; jtab[1] = 4'b1000; jtab[2] = 4'b1100; jtab[3] = 4'b1110;
        jtab[4] = 4'b1111; jtab[5] = 4'b0111; jtab[6] = 4'b0011; jtab[7] = 4'b0001;

        clear = 1'b1; en = 1'b1; skip_idle = 1'b0; req = 8'hFF;
        @(posedge clk);
        #1;
        // Grant must stay low under clear even with en and every req high.
        step("reset", 1'b1, 1'b0, 8'hFF, 8'h00, 4'b0000, 1'b0, 1'b0);
        clear = 1'b0;

        // Idle walk: one slot per cycle, wrap pulse after each 7->0 step.
        for (int k = 0; k <= 16; k++)
            step("walk", 1'b1, 1'b0, 8'h00, 8'h00, jtab[k % 8], (k == 8 || k == 16), 1'b0);

        // Fixed TDM with all requesting: four cycles per slot, 32-cycle frame.
        do_reset();
        for (int c = 0; c < 36; c++) begin
            s = (c / 4) % 8;
            g = 8'h01 << s;
            step("tdm_full", 1'b1, 1'b0, 8'hFF, g, jtab[s], (c == 32), 1'b0);
        end

        // Skip mode with requests on slots 2 and 5.
        do_reset();
        step("skip25_c0", 1'b1, 1'b1, 8'b0010_0100, 8'h00, jtab[0], 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++)
            step("skip25_s2", 1'b1, 1'b1, 8'b0010_0100, 8'h04, jtab[2], 1'b0, 1'b0);
        for (int c = 5; c <= 8; c++)
            step("skip25_s5", 1'b1, 1'b1, 8'b0010_0100, 8'h20, jtab[5], 1'b0, 1'b0);
        step("skip25_wrap", 1'b1, 1'b1, 8'b0010_0100, 8'h04, jtab[2], 1'b1, 1'b0);
        step("skip25_s2b",  1'b1, 1'b1, 8'b0010_0100, 8'h04, jtab[2], 1'b0, 1'b0);

        // Skip mode with a lone requester on slot 3: continuous grant, re-visit every 4 cycles.
        do_reset();
        step("lone3_c0", 1'b1, 1'b1, 8'h08, 8'h00, jtab[0], 1'b0, 1'b0);
        for (int c = 1; c <= 13; c++)
            step("lone3", 1'b1, 1'b1, 8'h08, 8'h08, jtab[3], (c >= 5 && ((c - 1) % 4) == 0), 1'b0);

        // Illegal state injection while enabled.
        do_reset();
        en = 1'b1; skip_idle = 1'b0; req = 8'hFF;
        force dut.jstate_q = 4'b0100;
        push_exp("illegal_en1", 8'h00, 4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        release dut.jstate_q;
        @(posedge clk);
        #1;
        step("recover_en1", 1'b1, 1'b0, 8'hFF, 8'h01, 4'b0000, 1'b0, 1'b1);
        step("after_en1",   1'b1, 1'b0, 8'hFF, 8'h01, 4'b0000, 1'b0, 1'b0);

        // Illegal state injection while disabled: recovery still happens.
        do_reset();
        en = 1'b0; skip_idle = 1'b0; req = 8'hFF;
        force dut.jstate_q = 4'b0100;
        push_exp("illegal_en0", 8'h00, 4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        release dut.jstate_q;
        @(posedge clk);
        #1;
        step("recover_en0", 1'b0, 1'b0, 8'hFF, 8'h00, 4'b0000, 1'b0, 1'b1);
        step("after_en0",   1'b0, 1'b0, 8'hFF, 8'h00, 4'b0000, 1'b0, 1'b0);

        // Clear asserted between edges in the middle of the slot 5 visit.
        do_reset();
        for (int c = 0; c < 22; c++) begin
            s = (c / 4) % 8;
            g = 8'h01 << s;
            step("pre_clear", 1'b1, 1'b0, 8'hFF, g, jtab[s], 1'b0, 1'b0);
        end
        en = 1'b1; req = 8'hFF;
        push_exp("clear_mid", 8'h00, 4'b0000, 1'b0, 1'b0);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        for (int c = 0; c < 3; c++)
            step("hold_en0", 1'b0, 1'b0, 8'hFF, 8'h00, 4'b0000, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            s = c / 4;
            g = 8'h01 << s;
            step("restart", 1'b1, 1'b0, 8'hFF, g, jtab[s], 1'b0, 1'b0);
        end

        // Let the monitor drain the queue, bounded.
        for (int w = 0; w < 10 && expq.size() > 0; w++) @(posedge clk);
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
